apb4_master_mux: RTL
====================

Name: apb4_master_mux

Overview:
- Parametrised APB4 master with built-in address decoder driving NUM_SLAVES completers over a shared APB bus with per-slave PSEL.
- Next generation of the single-master/dual-select APB pair:
  - generalised data/address width and slave count;
  - adds a valid/ready request port, PSLVERR error return, decode-error handling and an optional watchdog.
- Sits between a local requester (CPU/DMA shim) and the peripheral APB slaves.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; must be 8, 16 or 32.
- NUM_SLAVES, 4, number of completers (1..16).
- SLV_ADDR_W, 12, log2 bytes of the window per slave.
- BASE_ADDR, 32'h0000_0000, start of slave 0's window; must be aligned to 2^SLV_ADDR_W.
- TIMEOUT_CYC, 256, watchdog limit in ACCESS cycles; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  bus clock.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  write byte strobes.
- req_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 on writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes.
- PPROT  out  3  APB protection.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PREADY  in  NUM_SLAVES  per-slave ready.
- PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data, flattened; slave i occupies bits [i*DATA_W +: DATA_W].
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (synchronous, PRESET=1 at a PCLK edge):
  - state=IDLE;
  - all outputs 0 except req_ready=1.
- Reset takes effect mid-transfer. It aborts the transfer with no rsp_valid; PSEL and PENABLE drop on the next edge.
- States: IDLE, SETUP, ACCESS, DERR.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is registered.
  - Decode: idx = (req_addr - BASE_ADDR) >> SLV_ADDR_W.
  - If req_addr < BASE_ADDR or idx >= NUM_SLAVES, go to DERR. Otherwise go to SETUP.
- SETUP (1 cycle):
  - PSEL[idx]=1, PENABLE=0.
  - PADDR, PWRITE, PPROT, PWDATA driven from registered values.
  - PSTRB=req_strb for writes, all-zero for reads (APB4 rule).
  - Next state ACCESS.
- ACCESS:
  - PENABLE=1.
  - All address/control/data outputs held stable.
  - Only PREADY[idx], PRDATA slice idx and PSLVERR[idx] are observed; others ignored.
  - On PREADY[idx]=1:
    - next edge: state=IDLE, PSEL=0, PENABLE=0, rsp_valid=1;
    - rsp_err=PSLVERR[idx];
    - rsp_rdata = read and no error ? PRDATA slice : 0.
- DERR (1 cycle): no PSEL asserted; next edge rsp_valid=1, rsp_err=1, rsp_rdata=0; state=IDLE.
- Latency, zero-wait slave:
  - request accepted at edge N;
  - SETUP in cycle N+1, ACCESS in N+2;
  - rsp_valid in N+3, req_ready=1 in N+3.
- Back-to-back: a new request may be accepted in the rsp_valid cycle. PSEL then deasserts for exactly that one cycle.
- Response port has no backpressure; rsp_valid is high for exactly one cycle per accepted request.
- PADDR, PWDATA and PSTRB hold their last values in IDLE (no toggling); PENABLE is never 1 without a PSEL.
- Wait states are unbounded unless APB_TIMEOUT_EN is defined.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - a counter of width $clog2(TIMEOUT_CYC+1) clears on SETUP and increments each ACCESS cycle with PREADY[idx]=0;
  - at count == TIMEOUT_CYC-1 without PREADY, the transfer is abandoned: next edge PSEL/PENABLE drop, rsp_valid=1, rsp_err=1, rsp_rdata=0, state=IDLE.
  - PREADY arriving in the same cycle as the limit wins (normal completion).
- Undefined: no counter logic; TIMEOUT_CYC is ignored.

Decomposition:
- Package apb4_pkg:
  - state enum typedef (IDLE, SETUP, ACCESS, DERR);
  - PPROT field constants (PRIV=bit0, NONSEC=bit1, INSTR=bit2);
  - typedef apb_req_t struct {write, addr, wdata, strb, prot}, parameterised via localparam widths.
- One sub-module, apb4_addr_decoder (combinational):
  - inputs: addr;
  - outputs: idx, hit;
  - parameters: ADDR_W, NUM_SLAVES, SLV_ADDR_W, BASE_ADDR.
  - Reused by future interconnect blocks.

Test Plan:
- Write, zero-wait. Defaults; write addr 0x0000_1004, data 0xDEADBEEF, strb 4'hF.
  - PSEL=4'b0010 for 2 cycles; PENABLE high in the 2nd only; PSTRB=4'hF.
  - rsp_valid 3 cycles after accept, rsp_err=0.
- Read with waits. Read 0x0000_3000; slave 3 holds PREADY low 4 cycles, then returns 0x12345678.
  - ACCESS lasts 5 cycles; PSTRB=0; rsp_rdata=0x12345678.
- Decode error. Request to 0x0000_4000 (idx 4).
  - No PSEL bit ever set; rsp_valid 2 cycles after accept with rsp_err=1, rsp_rdata=0.
- Slave error. Read from slave 0 with PSLVERR=1 at completion, PRDATA=0xFFFF_FFFF.
  - rsp_err=1, rsp_rdata=0.
- Timeout and reset. With APB_TIMEOUT_EN and TIMEOUT_CYC=8, slave never ready.
  - rsp_err=1 after 8 ACCESS cycles.
  - Separately, assert PRESET during ACCESS: next edge PSEL=0, PENABLE=0, req_ready=1, no rsp_valid.
- Back-to-back. Two writes to slaves 1 then 2 with req_valid held.
  - Second request accepted in the first rsp_valid cycle; PSEL sequence 0010, 0010, 0000, 0100, 0100.

Source files
------------

// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 master and future interconnect blocks.
// Holds the master FSM state encoding, the PPROT bit positions and the
// registered request record. APB4 caps PADDR and PDATA at 32 bits, so the
// record is sized at those maxima. Narrower instances cast down on the way out.
package apb4_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
  localparam int APB_PROT_W = 3;

  // Bit positions inside PPROT
  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [APB_PROT_W-1:0] prot;
  } apb_req_t;

endpackage

// File: rtl/apb4_addr_decoder.sv
// Combinational window decoder. Each completer owns a 2^SLV_ADDR_W byte window.
// The windows are laid out contiguously from BASE_ADDR. hit is low for
// addresses below the base, and for addresses past the last window.
module apb4_addr_decoder #(
  parameter int              ADDR_W     = 32,
  parameter int              NUM_SLAVES = 4,
  parameter int              SLV_ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  localparam int             IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_slot;

  assign w_offset = addr - BASE_ADDR;
  assign w_slot   = w_offset >> SLV_ADDR_W;
  assign hit      = (addr >= BASE_ADDR) && (w_slot < ADDR_W'(NUM_SLAVES));
  assign idx      = w_slot[IDX_W-1:0];

endmodule

// File: rtl/apb4_master_mux.sv
// APB4 master with an integrated address decoder. The local requester presents
// requests on a valid/ready port. The block runs one APB transfer per request
// on the shared bus, using a per-slave PSEL. It returns a one-cycle response
// pulse with read data and an error flag. Decode misses go through a one-cycle
// DERR state and never touch the bus.
// Optional macro APB_TIMEOUT_EN: enables a watchdog. The watchdog abandons a
// transfer after TIMEOUT_CYC ACCESS cycles without PREADY.
module apb4_master_mux
  import apb4_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLAVES  = 4,
  parameter int                SLV_ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                TIMEOUT_CYC = 256
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  // request port
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  input  logic [2:0]                   req_prot,
  // response port
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  // APB bus
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  output logic [2:0]                   PPROT,
  output logic                         PWRITE,
  output logic                         PENABLE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_W / 8;

  apb_state_e        r_state;
  apb_state_e        w_next_state;
  apb_req_t          r_req;
  logic [IDX_W-1:0]  r_idx;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_accept;
  logic              w_sel_ready;
  logic              w_sel_err;
  logic [DATA_W-1:0] w_sel_rdata;
  logic              w_done;
  logic              w_timeout;

  apb4_addr_decoder #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_ADDR_W (SLV_ADDR_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decoder (
    .addr (req_addr),
    .idx  (w_idx),
    .hit  (w_hit)
  );

  // Only the addressed completer's ready, data and error are ever looked at
  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_sel_ready = PREADY[r_idx];
  assign w_sel_err   = PSLVERR[r_idx];
  assign w_sel_rdata = PRDATA[r_idx*DATA_W +: DATA_W];
  assign w_done      = (r_state == ACCESS) && w_sel_ready;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;

  // Watchdog: count ACCESS cycles spent waiting, restarting on every SETUP
  always_ff @(posedge PCLK) begin
    if (PRESET || (r_state == SETUP)) begin
      r_to_cnt <= '0;
    end else if ((r_state == ACCESS) && !w_sel_ready) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // A PREADY in the limit cycle wins, so the timeout is qualified by !ready
  assign w_timeout = (r_state == ACCESS) && !w_sel_ready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next_state = w_hit ? SETUP : DERR;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (w_sel_ready || w_timeout) w_next_state = IDLE;
      DERR:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Bus handshake outputs decoded from the current state
  always_comb begin
    PSEL      = '0;
    PENABLE   = 1'b0;
    req_ready = 1'b0;
    case (r_state)
      IDLE:    req_ready = 1'b1;
      SETUP:   PSEL = NUM_SLAVES'(1) << r_idx;
      ACCESS: begin
        PSEL    = NUM_SLAVES'(1) << r_idx;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture a decoded request. A miss leaves the bus lines unchanged.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_req <= '0;
      r_idx <= '0;
    end else if (w_accept && w_hit) begin
      r_req.write <= req_write;
      r_req.addr  <= APB_ADDR_W'(req_addr);
      r_req.wdata <= APB_DATA_W'(req_wdata);
      // Reads must present all-zero strobes
      r_req.strb  <= req_write ? APB_STRB_W'(req_strb) : '0;
      r_req.prot  <= req_prot;
      r_idx       <= w_idx;
    end
  end

  assign PADDR  = ADDR_W'(r_req.addr);
  assign PWDATA = DATA_W'(r_req.wdata);
  assign PSTRB  = STRB_W'(r_req.strb);
  assign PPROT  = r_req.prot;
  assign PWRITE = r_req.write;

  // Response pulse: completion, watchdog abort or decode error
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_done || w_timeout || (r_state == DERR);
      r_rsp_err   <= w_done ? w_sel_err : (w_timeout || (r_state == DERR));
      r_rsp_rdata <= (w_done && !r_req.write && !w_sel_err) ? w_sel_rdata : '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
